fib_arb: RTL and testbench
==========================

FIB_ARB -- requirements
Module: fib_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requester ports (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 63, giving the watchdog limit in WAIT cycles; it is used only when FIB_ARB_TIMEOUT_EN is defined.
REQ-003 clk  in  1  Single clock; all state updates on its rising edge.
REQ-004 rst  in  1  Reset, synchronous, active-high.
REQ-005 req  in  N_REQ  Per-requester request level.
REQ-006 req_n  in  4*N_REQ  Packed per-requester index n; slice i is bits [4i+3:4i].
REQ-007 hold  in  1  Global pause; forwarded to the engine.
REQ-008 resp_valid  out  N_REQ  One-hot, one-cycle completion pulse.
REQ-009 resp_f  out  10  Result for the requester flagged by resp_valid.
REQ-010 resp_err  out  1  Timeout flag, qualified by resp_valid.
REQ-011 eng_start  out  1  Start to the Fibonacci engine.
REQ-012 eng_n  out  4  Index to the engine.
REQ-013 eng_pause  out  1  Pause to the engine.
REQ-014 eng_busy  in  1  Engine busy.
REQ-015 eng_done  in  1  Engine one-cycle done pulse.
REQ-016 eng_f  in  10  Engine result, valid when eng_done is high.

Function
REQ-017 The block SHALL be a four-state FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: when any req bit is high, the block SHALL grant round-robin starting at index ptr+1 mod N_REQ, register gnt and req_n[gnt] into eng_n, and go to ISSUE.
REQ-019 ptr SHALL update to gnt at grant; a single requester SHALL be re-granted when it is alone.
REQ-020 ISSUE: eng_start SHALL equal (state==ISSUE) && !eng_busy && !hold, combinationally.
REQ-021 ISSUE SHALL go to WAIT on the first cycle in which eng_start is high and the engine samples it.
REQ-022 WAIT: eng_start SHALL be 0 and eng_n SHALL be held stable.
REQ-023 WAIT: on eng_done, the block SHALL capture eng_f into resp_f and go to RESP.
REQ-024 RESP SHALL last exactly one cycle with resp_valid[gnt]=1, then go to IDLE.
REQ-025 Throughput: a new grant SHALL NOT occur in the RESP cycle.
REQ-026 eng_pause SHALL equal hold combinationally.
REQ-027 While hold=1, the FSM SHALL not leave ISSUE, and the timeout counter SHALL freeze.
REQ-028 Handshake: req[i] and req_n slice i SHALL stay stable from assertion until resp_valid[i]; the block samples n only at grant.
REQ-029 A req bit dropped before grant SHALL be ignored (request withdrawn) with no response.
REQ-030 A req still high in the cycle after RESP SHALL be treated as a new request.
REQ-031 eng_done seen outside WAIT SHALL be ignored.
REQ-032 resp_f SHALL hold its last value outside RESP.

Reset
REQ-033 With rst=1 at a clock edge, the block SHALL go to state IDLE with ptr=N_REQ-1, so that the first grant goes to index 0.
REQ-034 With rst=1 at a clock edge, resp_valid, resp_f, resp_err, eng_n and the timeout counter SHALL all be cleared to 0.
REQ-035 Reset mid-operation SHALL abandon the in-flight request with no response.
REQ-036 After a mid-operation reset, the engine, which has no reset, may still be busy; ISSUE waits on !eng_busy, and a stale eng_done is ignored per REQ-031.

Configuration
REQ-037 With FIB_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each non-hold WAIT cycle.
REQ-038 With FIB_ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT without eng_done, the block SHALL enter RESP with resp_err=1 and resp_f=0.
REQ-039 With FIB_ARB_TIMEOUT_EN defined, if eng_done and expiry coincide, eng_done SHALL win.
REQ-040 With FIB_ARB_TIMEOUT_EN undefined, the counter SHALL be absent, resp_err SHALL be tied 0, and WAIT SHALL exit only on eng_done.

Verification
REQ-041 Single request: req[0]=1 with n=5 -> eng_start pulses once with eng_n=5, then resp_valid=4'b0001 with resp_f=8, resp_err=0.
REQ-042 Boundaries: n=0 -> resp_f=1, n=1 -> 1, n=4 -> 5, n=15 -> 987, for all four requesters.
REQ-043 Fairness: req=4'b1111 held continuously with n=3,6,9,12 -> responses in index order 0,1,2,3,0 with values 3,13,55,233,3.
REQ-044 Hold: hold=1 asserted during ISSUE for 10 cycles -> eng_start stays 0 and the state stays ISSUE; after hold=0, the result is still correct.
REQ-045 Reset: rst pulsed in WAIT with engine busy -> no resp_valid; the next request issues only after eng_busy=0 and returns the correct value.
REQ-046 Timeout (macro defined, TIMEOUT=8): engine model withholds eng_done -> resp_valid after 8 WAIT cycles with resp_err=1 and resp_f=0.

Source files
------------

// File: rtl/fib_arb.sv
// fib_arb: round-robin arbiter in front of a shared Fibonacci engine.
//   Requesters raise req[i] with an index in req_n slice i; one is granted,
//   its index is sent to the engine, and the result comes back as a one-cycle
//   resp_valid pulse on that requester's bit with the value in resp_f.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, req_n, hold  request levels, packed 4-bit indices, global pause
//   resp_valid/f/err  one-hot completion pulse, result, timeout flag
//   eng_start/n/pause start, index and pause towards the engine
//   eng_busy/done/f   engine status, done pulse and result
// Build option: define FIB_ARB_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT
//   cycles; without it resp_err is tied low and WAIT ends only on eng_done.
module fib_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_n,
  input  logic                 hold,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [9:0]           resp_f,
  output logic                 resp_err,
  output logic                 eng_start,
  output logic [3:0]           eng_n,
  output logic                 eng_pause,
  input  logic                 eng_busy,
  input  logic                 eng_done,
  input  logic [9:0]           eng_f
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] pick;
  logic          pick_vld;

  // Round-robin pick: scan from ptr+1 upwards, wrapping; the lowest offset wins.
  // Offset N_REQ lands back on ptr itself, so a lone requester is re-granted.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[IW'((int'(ptr) + k) % N_REQ)]) begin
        pick     = IW'((int'(ptr) + k) % N_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  // Engine only samples start when it is idle and nothing is paused.
  assign eng_start = (state == ISSUE) && !eng_busy && !hold;
  assign eng_pause = hold;

`ifdef FIB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign resp_err       = 1'b0;
`endif

  // Main control FSM; all outputs except eng_start/eng_pause are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IW'(N_REQ - 1);
      gnt        <= '0;
      eng_n      <= '0;
      resp_valid <= '0;
      resp_f     <= '0;
`ifdef FIB_ARB_TIMEOUT_EN
      resp_err   <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      resp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt   <= pick;
            ptr   <= pick;
            eng_n <= req_n[{pick, 2'b00} +: 4];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (eng_start) begin
            state <= WAIT;
`ifdef FIB_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          // eng_done takes priority over a coinciding watchdog expiry.
          if (eng_done) begin
            resp_f     <= eng_f;
            resp_valid <= N_REQ'(1) << gnt;
            state      <= RESP;
`ifdef FIB_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
          end else if (!hold) begin
            if (wd_cnt == CW'(TIMEOUT - 1)) begin
              resp_f     <= '0;
              resp_err   <= 1'b1;
              resp_valid <= N_REQ'(1) << gnt;
              state      <= RESP;
            end else begin
              wd_cnt <= wd_cnt + CW'(1);
            end
`endif
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_arb.sv
// Self-checking bench for fib_arb with a behavioural Fibonacci engine model.
module tb_fib_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [4*N-1:0]   req_n = '0;
  logic             hold = 1'b0;
  logic [N-1:0]     resp_valid;
  logic [9:0]       resp_f;
  logic             resp_err;
  logic             eng_start;
  logic [3:0]       eng_n;
  logic             eng_pause;
  logic             eng_busy = 1'b0;
  logic             eng_done = 1'b0;
  logic [9:0]       eng_f = '0;

  int checks = 0;
  int errors = 0;
  int rr_last = N - 1;
  int pn [N];

  fib_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_n(req_n), .hold(hold),
    .resp_valid(resp_valid), .resp_f(resp_f), .resp_err(resp_err),
    .eng_start(eng_start), .eng_n(eng_n), .eng_pause(eng_pause),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_f(eng_f)
  );

  function automatic logic [9:0] fib_ref(input int n);
    int a, b, t;
    a = 1; b = 1;
    for (int i = 2; i <= n; i++) begin t = a + b; a = b; b = t; end
    return 10'(b);
  endfunction

  // Round-robin reference: first requester after the last one served.
  function automatic int next_gnt(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Engine model: no reset, pausable countdown, optional done suppression.
  int         lat_fixed = 0;
  bit         withhold = 1'b0;
  bit         inject_done = 1'b0;
  int         lat_cnt = 0;
  int         start_cnt = 0;
  logic [3:0] eng_n_lat = '0;
  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (inject_done) begin
      eng_done <= 1'b1;
      eng_f    <= 10'h2AA;
    end
    if (eng_busy) begin
      if (!eng_pause) begin
        if (lat_cnt <= 1) begin
          eng_busy <= 1'b0;
          eng_done <= 1'b1;
          eng_f    <= fib_ref(int'(eng_n_lat));
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end else if (eng_start) begin
      start_cnt <= start_cnt + 1;
      eng_n_lat <= eng_n;
      if (!withhold) begin
        eng_busy <= 1'b1;
        lat_cnt  <= (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
      end
    end
  end

  task automatic set_req(input int i, input int n);
    req_n[4*i +: 4] = 4'(n);
    pn[i]  = n;
    req[i] = 1'b1;
  endtask

  task automatic wait_resp(input bit rand_hold, output logic [N-1:0] v,
                           output logic [9:0] f, output logic e, output bit ok);
    ok = 1'b0; v = '0; f = '0; e = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        v = resp_valid; f = resp_f; e = resp_err; ok = 1'b1;
        break;
      end
      if (rand_hold) hold = ($urandom_range(0, 3) == 0);
    end
    hold = 1'b0;
  endtask

  task automatic wait_start(input int base, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (start_cnt != base) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; hold = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    checks++; if (resp_f !== 10'd0) begin errors++; $display("FAIL reset_f got %0d exp 0", resp_f); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", resp_err); end
    checks++; if (eng_n !== 4'd0) begin errors++; $display("FAIL reset_eng_n got %0d exp 0", eng_n); end
    checks++; if (eng_start !== 1'b0 || eng_pause !== 1'b0) begin errors++; $display("FAIL reset_eng got start=%b pause=%b exp 0 0", eng_start, eng_pause); end
    rst = 1'b0;
    rr_last = N - 1;
  endtask

  task automatic test_single;
    logic [N-1:0] v; logic [9:0] f; logic e; bit ok; int base;
    base = start_cnt;
    set_req(0, 5);
    wait_resp(1'b0, v, f, e, ok);
    req = '0;
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got none exp response"); end
    checks++; if (v !== 4'b0001 || f !== 10'd8 || e !== 1'b0) begin errors++; $display("FAIL single_resp got v=%b f=%0d e=%b exp 0001 8 0", v, f, e); end
    checks++; if (start_cnt - base != 1 || eng_n_lat !== 4'd5) begin errors++; $display("FAIL single_start got starts=%0d n=%0d exp 1 5", start_cnt - base, eng_n_lat); end
    rr_last = 0;
    @(negedge clk);
    checks++; if (resp_valid !== '0 || resp_f !== 10'd8) begin errors++; $display("FAIL single_hold_f got v=%b f=%0d exp 0 8", resp_valid, resp_f); end
  endtask

  task automatic test_boundaries;
    logic [N-1:0] v; logic [9:0] f; logic e; bit ok;
    int           ns   [4] = '{0, 1, 4, 15};
    logic [9:0]   fexp [4] = '{10'd1, 10'd1, 10'd5, 10'd987};
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 4; j++) begin
        set_req(i, ns[j]);
        wait_resp(1'b0, v, f, e, ok);
        req = '0;
        checks++;
        if (!ok || v !== (N'(1) << i) || f !== fexp[j] || e !== 1'b0) begin
          errors++;
          $display("FAIL boundary_%0d_n%0d got v=%b f=%0d e=%b exp %b %0d 0", i, ns[j], v, f, e, N'(1) << i, fexp[j]);
        end
        rr_last = i;
      end
    end
  endtask

  task automatic test_fairness;
    logic [N-1:0] v; logic [9:0] f; logic e; bit ok; int ex;
    logic [9:0] fexp [4] = '{10'd3, 10'd13, 10'd55, 10'd233};
    set_req(0, 3); set_req(1, 6); set_req(2, 9); set_req(3, 12);
    for (int t = 0; t < 5; t++) begin
      ex = next_gnt(req, rr_last);
      wait_resp(1'b0, v, f, e, ok);
      checks++;
      if (!ok || v !== (N'(1) << ex) || f !== fexp[ex]) begin
        errors++;
        $display("FAIL fairness_%0d got v=%b f=%0d exp %b %0d", t, v, f, N'(1) << ex, fexp[ex]);
      end
      rr_last = ex;
    end
    req = '0;
  endtask

  task automatic test_hold;
    logic [N-1:0] v; logic [9:0] f; logic e; bit ok; int base; int bad;
    bad  = 0;
    base = start_cnt;
    hold = 1'b1;
    set_req(1, 7);
    repeat (10) begin
      @(negedge clk);
      if (eng_start !== 1'b0 || eng_pause !== 1'b1) bad++;
    end
    checks++; if (bad != 0 || start_cnt != base) begin errors++; $display("FAIL hold_issue got bad=%0d starts=%0d exp 0 0", bad, start_cnt - base); end
    hold = 1'b0;
    #1;
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL hold_release got start=%b exp 1", eng_start); end
    wait_resp(1'b0, v, f, e, ok);
    req = '0;
    checks++; if (!ok || v !== 4'b0010 || f !== 10'd21) begin errors++; $display("FAIL hold_resp got v=%b f=%0d exp 0010 21", v, f); end
    rr_last = 1;
  endtask

  task automatic test_withdraw;
    logic [N-1:0] v; logic [9:0] f; logic e; bit ok; int base; int spur;
    lat_fixed = 6;
    base = start_cnt;
    set_req(0, 7);
    wait_start(base, ok);
    set_req(1, 9);
    repeat (2) @(negedge clk);
    req[1] = 1'b0;
    wait_resp(1'b0, v, f, e, ok);
    req = '0;
    checks++; if (!ok || v !== 4'b0001 || f !== 10'd21) begin errors++; $display("FAIL withdraw_resp got v=%b f=%0d exp 0001 21", v, f); end
    rr_last = 0;
    // Stray engine done while idle must not produce a response.
    base = start_cnt; spur = 0;
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid !== '0) spur++;
    end
    checks++; if (spur != 0 || start_cnt != base || resp_f !== 10'd21) begin errors++; $display("FAIL withdraw_idle got spur=%0d starts=%0d f=%0d exp 0 0 21", spur, start_cnt - base, resp_f); end
    lat_fixed = 0;
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] v; logic [9:0] f; logic e; bit ok; int base; int bad;
    lat_fixed = 6;
    base = start_cnt;
    set_req(2, 10);
    wait_start(base, ok);
    @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (resp_valid !== '0 || resp_f !== 10'd0 || eng_n !== 4'd0) begin errors++; $display("FAIL midreset_clear got v=%b f=%0d n=%0d exp 0 0 0", resp_valid, resp_f, eng_n); end
    checks++; if (eng_busy !== 1'b1) begin errors++; $display("FAIL midreset_busy got %b exp 1", eng_busy); end
    rr_last = N - 1;
    set_req(0, 15); set_req(3, 2);
    bad = 0; v = '0; ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (eng_start && eng_busy) bad++;
      if (resp_valid != '0) begin v = resp_valid; f = resp_f; ok = 1'b1; break; end
    end
    req[0] = 1'b0;
    checks++; if (!ok || bad != 0 || v !== 4'b0001 || f !== 10'd987) begin errors++; $display("FAIL midreset_first got v=%b f=%0d bad=%0d exp 0001 987 0", v, f, bad); end
    wait_resp(1'b0, v, f, e, ok);
    req = '0;
    checks++; if (!ok || v !== 4'b1000 || f !== 10'd2) begin errors++; $display("FAIL midreset_second got v=%b f=%0d exp 1000 2", v, f); end
    rr_last = 3;
    lat_fixed = 0;
  endtask

`ifdef FIB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [N-1:0] v; bit ok; int base; int cnt;
    withhold = 1'b1;
    base = start_cnt;
    set_req(1, 3);
    wait_start(base, ok);
    cnt = 0;
    while (resp_valid == '0 && cnt < 100) begin cnt++; @(negedge clk); end
    v = resp_valid;
    checks++; if (cnt != int'(TO)) begin errors++; $display("FAIL timeout_cycles got %0d exp %0d", cnt, TO); end
    checks++; if (v !== 4'b0010 || resp_err !== 1'b1 || resp_f !== 10'd0) begin errors++; $display("FAIL timeout_resp got v=%b e=%b f=%0d exp 0010 1 0", v, resp_err, resp_f); end
    req = '0;
    withhold = 1'b0;
    rr_last = 1;
    @(negedge clk);
  endtask
`endif

  task automatic test_random;
    logic [N-1:0] v; logic [9:0] f; logic e; bit ok; int ex;
    req = '0;
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 1) == 1) set_req(i, int'($urandom_range(0, 15)));
    if (req == '0) set_req(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)));
    for (int t = 0; t < 40; t++) begin
      ex = next_gnt(req, rr_last);
      wait_resp(1'b1, v, f, e, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL random_%0d_timeout got none exp port %0d", t, ex); req = '0; return; end
      checks++;
      if (v !== (N'(1) << ex) || f !== fib_ref(pn[ex]) || e !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d got v=%b f=%0d e=%b exp %b %0d 0", t, v, f, e, N'(1) << ex, fib_ref(pn[ex]));
      end
      rr_last = ex;
      req[ex] = 1'b0;
      for (int j = 0; j < N; j++)
        if (!req[j] && $urandom_range(0, 2) == 0) set_req(j, int'($urandom_range(0, 15)));
      if (req == '0) set_req(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)));
    end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_boundaries;
    test_fairness;
    test_hold;
    test_withdraw;
    test_reset_mid;
`ifdef FIB_ARB_TIMEOUT_EN
    test_timeout;
`endif
    test_random;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
